// File: rtl/ad9910_write_sequencer.sv
// ad9910_write_sequencer
//   Turns one AD9910 register write into the timed 128-bit RTO word stream
//   consumed by the driver: per chunk a SPI CFG word followed by a DATA word,
//   then an optional IO_UPDATE high/low pair. Words are pushed one per cycle
//   whenever the driver FIFO is not full.
//
// Ports
//   clk            system clock
//   reset          asynchronous active-low reset
//   counter        global timestamp counter
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_addr, cmd_width, cmd_data, cmd_cs, cmd_upd_mask, cmd_time  command fields
//   rto_fifo_full  driver FIFO back-pressure
//   write_rto_fifo, rto_fifo_din  registered word write
//   busy           sequence in progress
//   seq_done       pulse in the first IDLE cycle after the final word
//   late           pulse the cycle after accept when cmd_time was clamped
//
// State table
//   IDLE   | waiting for a command
//   CFG    | emit SPI config word for current chunk
//   DATA   | emit data word for current chunk
//   UPD_HI | emit IO_UPDATE rising word
//   UPD_LO | emit IO_UPDATE falling word
module ad9910_write_sequencer #(
  parameter int                         NUM_CS         = 2,
  parameter int                         CHANNEL_LENGTH = 12,
  parameter logic [CHANNEL_LENGTH-1:0]  DEST_VAL       = 'h1,
  parameter logic [31:0]                CFG_BASE       = 32'h0,
  parameter int                         CFG_GAP        = 2,
  parameter int                         BIT_CYCLES     = 4,
  parameter int                         DATA_OVH       = 8,
  parameter int                         UPD_WIDTH      = 4,
  parameter int                         MIN_LEAD       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       counter,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_addr,
  input  logic [1:0]        cmd_width,
  input  logic [63:0]       cmd_data,
  input  logic [NUM_CS-1:0] cmd_cs,
  input  logic [1:0]        cmd_upd_mask,
  input  logic [63:0]       cmd_time,
  input  logic              rto_fifo_full,
  output logic              write_rto_fifo,
  output logic [127:0]      rto_fifo_din,
  output logic              busy,
  output logic              seq_done,
  output logic              late
);

  localparam int TYPE_W = 16 - CHANNEL_LENGTH;
  localparam logic [TYPE_W-1:0] TY_DATA  = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] TY_CFG   = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] TY_IOUPD = TYPE_W'(2);

  typedef enum logic [2:0] {IDLE, CFG, DATA, UPD_HI, UPD_LO} state_t;

  state_t              state_q, state_d;
  logic [63:0]         t_q, t_d;
  logic [1:0]          chunk_q, chunk_d;
  logic [4:0]          addr_q;
  logic [1:0]          width_q;
  logic [63:0]         data_q;
  logic [NUM_CS-1:0]   cs_q;
  logic [1:0]          upd_q;

  logic                accept;
  logic [63:0]         min_t;
  logic                clamp;
  logic [1:0]          last_chunk;
  logic [5:0]          bits;
  logic [31:0]         chunk_pl;
  logic [31:0]         cfg_pl;
  logic                wr_d;
  logic [127:0]        din_d;
  logic                done_d;
  logic                late_d;

  function automatic logic [127:0] make_word(input logic [63:0] ts,
                                             input logic [TYPE_W-1:0] ty,
                                             input logic [31:0] pl);
    return {ts, 16'h0, ty, DEST_VAL, pl};
  endfunction

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Wrapping 64-bit arithmetic: the clamp compares against the wrapped sum.
  assign min_t = counter + 64'(MIN_LEAD);
  assign clamp = (cmd_time < min_t);

  // Width codes 2 and 3 are both 64-bit: three chunks (instr, hi, lo).
  assign last_chunk = width_q[1] ? 2'd2 : 2'd1;

  always_comb begin
    bits     = 6'd8;
    chunk_pl = {3'b000, addr_q, 24'h0};
    case (chunk_q)
      2'd0: begin
        bits     = 6'd8;
        chunk_pl = {3'b000, addr_q, 24'h0};
      end
      2'd1: begin
        if (width_q == 2'd0) begin
          bits     = 6'd16;
          chunk_pl = {data_q[15:0], 16'h0};
        end else if (width_q == 2'd1) begin
          bits     = 6'd32;
          chunk_pl = data_q[31:0];
        end else begin
          bits     = 6'd32;
          chunk_pl = data_q[63:32];
        end
      end
      default: begin
        bits     = 6'd32;
        chunk_pl = data_q[31:0];
      end
    endcase

    cfg_pl                = CFG_BASE;
    cfg_pl[5:0]           = bits;
    cfg_pl[6]             = (chunk_q != last_chunk);
    cfg_pl[6+NUM_CS:7]    = cs_q;
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    chunk_d = chunk_q;
    wr_d    = 1'b0;
    din_d   = rto_fifo_din;
    done_d  = 1'b0;
    late_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          t_d     = clamp ? min_t : cmd_time;
          late_d  = clamp;
          chunk_d = 2'd0;
          state_d = CFG;
        end
      end
      CFG: begin
        if (!rto_fifo_full) begin
          wr_d    = 1'b1;
          din_d   = make_word(t_q, TY_CFG, cfg_pl);
          t_d     = t_q + 64'(CFG_GAP);
          state_d = DATA;
        end
      end
      DATA: begin
        if (!rto_fifo_full) begin
          wr_d  = 1'b1;
          din_d = make_word(t_q, TY_DATA, chunk_pl);
          t_d   = t_q + ({58'h0, bits} * 64'(BIT_CYCLES)) + 64'(DATA_OVH);
          if (chunk_q != last_chunk) begin
            chunk_d = chunk_q + 2'd1;
            state_d = CFG;
          end else if (upd_q != 2'b00) begin
            state_d = UPD_HI;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      UPD_HI: begin
        if (!rto_fifo_full) begin
          wr_d    = 1'b1;
          din_d   = make_word(t_q, TY_IOUPD, {30'h0, upd_q});
          t_d     = t_q + 64'(UPD_WIDTH);
          state_d = UPD_LO;
        end
      end
      UPD_LO: begin
        if (!rto_fifo_full) begin
          wr_d    = 1'b1;
          din_d   = make_word(t_q, TY_IOUPD, 32'h0);
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // seq_done is registered alongside the final strobe, so it lands in the
  // first IDLE cycle; a held cmd_valid is accepted in that same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      t_q            <= '0;
      chunk_q        <= '0;
      addr_q         <= '0;
      width_q        <= '0;
      data_q         <= '0;
      cs_q           <= '0;
      upd_q          <= '0;
      write_rto_fifo <= 1'b0;
      rto_fifo_din   <= '0;
      seq_done       <= 1'b0;
      late           <= 1'b0;
    end else begin
      state_q        <= state_d;
      t_q            <= t_d;
      chunk_q        <= chunk_d;
      write_rto_fifo <= wr_d;
      rto_fifo_din   <= din_d;
      seq_done       <= done_d;
      late           <= late_d;
      if (accept) begin
        addr_q  <= cmd_addr;
        width_q <= cmd_width;
        data_q  <= cmd_data;
        cs_q    <= cmd_cs;
        upd_q   <= cmd_upd_mask;
      end
    end
  end

endmodule
